// File: rtl/data_sram_bridge.sv
// data_sram_bridge: turns one M-stage load/store into exactly one SRAM-like bus
// transaction, stalls the pipeline until it completes, and returns the raw word.
module data_sram_bridge #(
  parameter int ADDR_W      = 32,
  parameter int TIMEOUT_CYC = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m_req,
  input  logic [3:0]        m_wen,
  input  logic [ADDR_W-1:0] m_addr,
  input  logic [31:0]       m_wdata,
  input  logic              pipe_stall,
  output logic [31:0]       m_rdata,
  output logic              m_stall,
  output logic              m_err,
  output logic              data_req,
  output logic              data_wr,
  output logic [1:0]        data_size,
  output logic [ADDR_W-1:0] data_addr,
  output logic [3:0]        data_wstrb,
  output logic [31:0]       data_wdata,
  input  logic              data_addr_ok,
  input  logic              data_ok,
  input  logic [31:0]       data_rdata
);

  // Counter only has to reach TIMEOUT_CYC-1; the abort fires on that cycle.
  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, HOLD} state_t;

  state_t            state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [31:0]       rdata_n;
  logic              err_n;
  logic              req_n;
  logic              wr_n;
  logic [1:0]        size_n;
  logic [ADDR_W-1:0] addr_n;
  logic [3:0]        wstrb_n;
  logic [31:0]       wdata_n;

  logic              req_wr;
  logic [1:0]        req_size;
  logic              req_misaligned;
  logic              timeout_hit;

  // Bus size code from an unshifted store mask (SB/SH/SW).
  function automatic logic [1:0] mask_size(input logic [3:0] wen);
    if (wen[3])      return 2'd2;
    else if (wen[1]) return 2'd1;
    else             return 2'd0;
  endfunction

  // Replicate the right-justified store operand across all byte lanes.
  function automatic logic [31:0] lane_wdata(input logic [31:0] wd, input logic [1:0] size);
    case (size)
      2'd0:    return {4{wd[7:0]}};
      2'd1:    return {2{wd[15:0]}};
      default: return wd;
    endcase
  endfunction

  assign req_wr         = |m_wen;
  assign req_size       = req_wr ? mask_size(m_wen) : 2'd2;
  assign req_misaligned = req_wr && (((req_size == 2'd1) && m_addr[0]) ||
                                     ((req_size == 2'd2) && (m_addr[1:0] != 2'b00)));
  assign timeout_hit    = (TIMEOUT_CYC > 0) && (cnt == CNT_LAST);

  // Stall is combinational so the hazard unit sees it in the request cycle.
  assign m_stall = m_req && (state != HOLD);

  // State register and registered bus/result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      m_rdata    <= '0;
      m_err      <= 1'b0;
      data_req   <= 1'b0;
      data_wr    <= 1'b0;
      data_size  <= 2'd0;
      data_addr  <= '0;
      data_wstrb <= 4'b0000;
      data_wdata <= '0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      m_rdata    <= rdata_n;
      m_err      <= err_n;
      data_req   <= req_n;
      data_wr    <= wr_n;
      data_size  <= size_n;
      data_addr  <= addr_n;
      data_wstrb <= wstrb_n;
      data_wdata <= wdata_n;
    end
  end

  // Next-state and next-output logic; a completing data_ok wins over a timeout.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    rdata_n = m_rdata;
    err_n   = 1'b0;
    req_n   = data_req;
    wr_n    = data_wr;
    size_n  = data_size;
    addr_n  = data_addr;
    wstrb_n = data_wstrb;
    wdata_n = data_wdata;
    case (state)
      IDLE: begin
        if (m_req) begin
          cnt_n = '0;
          if (req_misaligned) begin
            state_n = HOLD;
            err_n   = 1'b1;
            rdata_n = '0;
            req_n   = 1'b0;
          end else begin
            state_n = ADDR;
            req_n   = 1'b1;
            wr_n    = req_wr;
            size_n  = req_size;
            addr_n  = req_wr ? m_addr : {m_addr[ADDR_W-1:2], 2'b00};
            wstrb_n = req_wr ? 4'(m_wen << m_addr[1:0]) : 4'b0000;
            wdata_n = lane_wdata(m_wdata, req_size);
          end
        end
      end
      ADDR: begin
        if (data_addr_ok && data_ok) begin
          state_n = HOLD;
          req_n   = 1'b0;
          rdata_n = data_rdata;
        end else if (timeout_hit) begin
          state_n = HOLD;
          req_n   = 1'b0;
          err_n   = 1'b1;
          rdata_n = '0;
        end else begin
          cnt_n = cnt + 1'b1;
          if (data_addr_ok) begin
            state_n = DATA;
            req_n   = 1'b0;
          end
        end
      end
      DATA: begin
        if (data_ok) begin
          state_n = HOLD;
          rdata_n = data_rdata;
        end else if (timeout_hit) begin
          state_n = HOLD;
          err_n   = 1'b1;
          rdata_n = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      HOLD: begin
        if (!pipe_stall) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule
